// File: rtl/n64_demux_ctrl_pkg.sv
// Shared constants and types for the N64 video demux controller:
// parameter-word layout, sync nibble bits, deblur codes and lock states.
package n64_demux_ctrl_pkg;

    localparam int unsigned LINE_CNT_W = 10;
    localparam int unsigned DEMUX_W    = 5;

    localparam int unsigned DEMUX_CNT_HI      = 4;
    localparam int unsigned DEMUX_CNT_LO      = 3;
    localparam int unsigned DEMUX_VMODE_BIT   = 2;
    localparam int unsigned DEMUX_NDEBLUR_BIT = 1;
    localparam int unsigned DEMUX_N15BIT_BIT  = 0;

    localparam int unsigned SYNC_NVSYNC = 3;
    localparam int unsigned SYNC_NCLAMP = 2;
    localparam int unsigned SYNC_NHSYNC = 1;
    localparam int unsigned SYNC_NCSYNC = 0;

    localparam logic [1:0] DEBLUR_OFF     = 2'b00;
    localparam logic [1:0] DEBLUR_FORCED  = 2'b01;
    localparam logic [1:0] DEBLUR_AUTO    = 2'b10;
    localparam logic [1:0] DEBLUR_OFF_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic [1:0] data_cnt;
        logic       vmode;
        logic       ndo_deblur;
        logic       n15bit_mode;
    } demux_params_t;

    localparam demux_params_t PARAMS_RESET = '{
        data_cnt:    2'b00,
        vmode:       1'b0,
        ndo_deblur:  1'b1,
        n15bit_mode: 1'b1
    };

endpackage

// File: rtl/n64_line_counter.sv
// Sync-nibble edge detection, saturating lines-per-field counter and
// capture of the completed field's line count.
module n64_line_counter
    import n64_demux_ctrl_pkg::*;
#(
    parameter int unsigned LINE_MAX = 340
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ndsync,
    input  logic [3:0]            sync,
    output logic                  hs_fall_c,
    output logic                  vs_fall_c,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic [LINE_CNT_W-1:0] frame_lines
);

    localparam logic [LINE_CNT_W-1:0] LINE_SAT = LINE_CNT_W'(LINE_MAX + 1);

    logic [3:0] sync_prev;
    logic       unused_sync;

    // Edges only exist on sync-nibble cycles.
    assign hs_fall_c = !ndsync && sync_prev[SYNC_NHSYNC] && !sync[SYNC_NHSYNC];
    assign vs_fall_c = !ndsync && sync_prev[SYNC_NVSYNC] && !sync[SYNC_NVSYNC];

    assign unused_sync = sync_prev[SYNC_NCLAMP] ^ sync_prev[SYNC_NCSYNC];

    // vsync wins over a coincident hsync: the line is dropped, not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_prev   <= 4'hF;
            line_cnt    <= '0;
            frame_lines <= '0;
        end else begin
            if (!ndsync) begin
                sync_prev <= sync;
            end
            if (vs_fall_c) begin
                frame_lines <= line_cnt;
                line_cnt    <= '0;
            end else if (hs_fall_c && (line_cnt < LINE_SAT)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/n64_demux_ctrl.sv
// Cadence tracking, PAL/NTSC and 240p/480i detection, lock FSM and
// field-boundary gated demux parameter word for the N64 demultiplexer.
module n64_demux_ctrl
    import n64_demux_ctrl_pkg::*;
#(
    parameter int unsigned color_width = 7,
    parameter int unsigned LINE_MIN    = 200,
    parameter int unsigned LINE_MAX    = 340,
    parameter int unsigned LINE_THRES  = 288,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                   VCLK,
    input  logic                   VRST,
    input  logic                   nDSYNC,
    input  logic [color_width-1:0] D_i,
    input  logic [1:0]             deblur_mode_i,
    input  logic                   n15bit_mode_i,
    output logic [DEMUX_W-1:0]     demuxparams_o,
    output logic                   locked_o,
    output logic                   interlaced_o,
    output logic [LINE_CNT_W-1:0]  frame_lines_o
);

    localparam logic [LINE_CNT_W-1:0] LMIN   = LINE_CNT_W'(LINE_MIN);
    localparam logic [LINE_CNT_W-1:0] LMAX   = LINE_CNT_W'(LINE_MAX);
    localparam logic [LINE_CNT_W-1:0] LTHRES = LINE_CNT_W'(LINE_THRES);
    localparam int unsigned           VCNT_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [VCNT_W-1:0]     VCNT_LOCK = VCNT_W'(LOCK_FRAMES);

    lock_state_t             state, state_next;
    logic [VCNT_W-1:0]       valid_cnt, valid_cnt_next;
    demux_params_t           params, params_next;
    logic                    locked_next, interlaced_next;
    logic                    hs_fall, vs_fall;
    logic [LINE_CNT_W-1:0]   line_cnt, frame_lines;
    logic                    field_valid, saturated;
    logic                    unused_data;

    assign unused_data = ^D_i[color_width-1:4];

    n64_line_counter #(
        .LINE_MAX (LINE_MAX)
    ) u_line_counter (
        .clk         (VCLK),
        .rst         (VRST),
        .ndsync      (nDSYNC),
        .sync        (D_i[3:0]),
        .hs_fall_c   (hs_fall),
        .vs_fall_c   (vs_fall),
        .line_cnt    (line_cnt),
        .frame_lines (frame_lines)
    );

    assign field_valid = (line_cnt >= LMIN) && (line_cnt <= LMAX);
    assign saturated   = (line_cnt > LMAX);

    always_ff @(posedge VCLK) begin
        if (VRST) begin
            state     <= ST_SEARCH;
            valid_cnt <= '0;
        end else begin
            state     <= state_next;
            valid_cnt <= valid_cnt_next;
        end
    end

    // SEARCH only aligns the counter; the first complete field is judged in MEASURE.
    always_comb begin
        state_next     = state;
        valid_cnt_next = valid_cnt;
        unique case (state)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_next     = ST_MEASURE;
                    valid_cnt_next = '0;
                end
            end
            ST_MEASURE: begin
                if (vs_fall) begin
                    if (!field_valid) begin
                        valid_cnt_next = '0;
                    end else begin
                        valid_cnt_next = valid_cnt + 1'b1;
                        if (valid_cnt_next >= VCNT_LOCK) begin
                            state_next = ST_LOCKED;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (saturated || (vs_fall && !field_valid)) begin
                    state_next = ST_SEARCH;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    always_comb begin
        params_next          = params;
        locked_next          = (state_next == ST_LOCKED);
        interlaced_next      = interlaced_o;
        params_next.data_cnt = !nDSYNC ? 2'b01 : params.data_cnt + 2'd1;

        if (!locked_next) begin
            params_next.vmode = 1'b0;
            interlaced_next   = 1'b0;
        end else if (vs_fall && field_valid) begin
            params_next.vmode = (line_cnt >= LTHRES);
            interlaced_next   = (line_cnt != frame_lines);
        end

        // Mode inputs are only sampled at the field boundary.
        if (vs_fall) begin
            params_next.n15bit_mode = n15bit_mode_i;
            unique case (deblur_mode_i)
                DEBLUR_FORCED:            params_next.ndo_deblur = interlaced_next;
                DEBLUR_AUTO:              params_next.ndo_deblur = !(locked_next && !interlaced_next);
                DEBLUR_OFF, DEBLUR_OFF_ALT: params_next.ndo_deblur = 1'b1;
                default:                  params_next.ndo_deblur = 1'b1;
            endcase
        end
    end

    always_ff @(posedge VCLK) begin
        if (VRST) begin
            params       <= PARAMS_RESET;
            locked_o     <= 1'b0;
            interlaced_o <= 1'b0;
        end else begin
            params       <= params_next;
            locked_o     <= locked_next;
            interlaced_o <= interlaced_next;
        end
    end

    assign demuxparams_o[DEMUX_CNT_HI:DEMUX_CNT_LO] = params.data_cnt;
    assign demuxparams_o[DEMUX_VMODE_BIT]           = params.vmode;
    assign demuxparams_o[DEMUX_NDEBLUR_BIT]         = params.ndo_deblur;
    assign demuxparams_o[DEMUX_N15BIT_BIT]          = params.n15bit_mode;
    assign frame_lines_o                            = frame_lines;

endmodule
